// File: rtl/spi_reg_master.sv
// SPI initiator for the 16-bit register-bank frame (8-bit address, 8-bit value, MSB first).
// Drives spi_clk/cs/special/mosi from the system clock and captures MISO into rx_data.
module spi_reg_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [7:0]  val,
  input  logic        special_sel,
  output logic        ready,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_special,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StSetup = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StCsup  = 3'd5;
  localparam logic [2:0] StPost  = 3'd6;

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  // Half-period index 30 is the high phase after rise 15; its end is the last fall.
  localparam logic [4:0] LastHp = 5'd30;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      hp_q, hp_d;
  logic [15:0]     tx_q, tx_d;
  logic [15:0]     rx_sh_q, rx_sh_d;
  logic [15:0]     rx_data_q, rx_data_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;
  logic            special_q, special_d;
  logic            mosi_q, mosi_d;
  logic            tick;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    hp_d      = hp_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    special_d = special_q;
    mosi_d    = mosi_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start && ready_q) begin
          state_d   = StPre;
          tx_d      = {addr, val};
          special_d = !special_sel;
          ready_d   = 1'b0;
        end
      end
      StPre: begin
        if (tick) begin
          state_d = StSetup;
          cs_d    = 1'b0;
          mosi_d  = tx_q[15];
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[14:0], spi_miso};
          hp_d    = '0;
        end
      end
      StShift: begin
        if (tick) begin
          if (hp_q == LastHp) begin
            state_d = StHold;
            sclk_d  = 1'b0;
          end else begin
            hp_d = hp_q + 5'd1;
            if (hp_q[0]) begin
              // Rise k>=1: sample MISO and present the next MOSI bit.
              sclk_d  = 1'b1;
              rx_sh_d = {rx_sh_q[14:0], spi_miso};
              tx_d    = {tx_q[14:0], 1'b0};
              mosi_d  = tx_q[14];
            end else begin
              sclk_d = 1'b0;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StCsup;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      StCsup: begin
        if (tick) begin
          state_d   = StPost;
          special_d = 1'b1;
        end
      end
      StPost: begin
        if (tick) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hp_q      <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      special_q <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      special_q <= special_d;
      mosi_q    <= mosi_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign rx_data     = rx_data_q;
  assign spi_clk     = sclk_q;
  assign spi_cs      = cs_q;
  assign spi_special = special_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Randomized bench for spi_reg_master: a slave-side model drives MISO, records MOSI and edge
// timing per frame, and compares them with the frame timeline computed from D.
module tb_spi_reg_master;

  localparam int D = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  addr;
  logic [7:0]  val;
  logic        special_sel;
  logic        ready;
  logic        done;
  logic [15:0] rx_data;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_special;
  logic        spi_mosi;
  logic        spi_miso;

  int n_checks;
  int n_pass;

  spi_reg_master #(
    .CLK_DIV(D)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .val        (val),
    .special_sel(special_sel),
    .ready      (ready),
    .done       (done),
    .rx_data    (rx_data),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_special(spi_special),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_cs"}, int'(spi_cs), 1);
    check({pfx, "_special"}, int'(spi_special), 1);
    check({pfx, "_sclk"}, int'(spi_clk), 0);
    check({pfx, "_mosi"}, int'(spi_mosi), 0);
    check({pfx, "_ready"}, int'(ready), 1);
    check({pfx, "_done"}, int'(done), 0);
    check({pfx, "_rx"}, int'(rx_data), 0);
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // Cycle c = c-th cycle after the edge that samples start (start sampled in cycle 0).
  task automatic run_frame(input logic [7:0] a, input logic [7:0] v, input logic sel,
                           input logic [15:0] w, input int busy_at, input int abort_fall,
                           input bit hold);
    int nfall, fall_err, sp_lo, sp_hi, cs_lo, cs_hi, dn, ndone, sp_after, limit;
    logic [15:0] mosi_w, rx_at;
    logic prev_clk, prev_cs, prev_sp, rdy_at;
    nfall = 0; fall_err = 0; sp_lo = -1; sp_hi = -1; cs_lo = -1; cs_hi = -1;
    dn = -1; ndone = 0; sp_after = -1; limit = 1 + 36 * D + 4;
    mosi_w = '0; rx_at = '0; rdy_at = 1'b0;
    @(negedge clk);
    addr = a; val = v; special_sel = sel; spi_miso = w[15]; start = 1'b1;
    @(posedge clk);
    prev_clk = 1'b0; prev_cs = 1'b1; prev_sp = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (rst) begin
        check_idle("abort");
        rst = 1'b0;
      end
      if (c == 1 && !hold) start = 1'b0;
      if (c == 5) begin
        addr = ~a; val = ~v;
        if (!hold) special_sel = ~sel;
      end
      if (c == busy_at) start = 1'b1;
      if (c == busy_at + 1) start = 1'b0;
      if (prev_sp && !spi_special && sp_lo < 0) sp_lo = c;
      if (!prev_sp && spi_special && sp_hi < 0) sp_hi = c;
      if (prev_cs && !spi_cs && cs_lo < 0) cs_lo = c;
      if (!prev_cs && spi_cs && cs_hi < 0) cs_hi = c;
      if (prev_clk && !spi_clk) begin
        if (c != 1 + 3 * D + 2 * nfall * D) fall_err++;
        mosi_w = {mosi_w[14:0], spi_mosi};
        nfall++;
        if (nfall < 16) spi_miso = w[15 - nfall];
        if (nfall == abort_fall + 1) rst = 1'b1;
      end
      if (done) begin
        ndone++;
        if (dn < 0) begin
          dn = c; rx_at = rx_data; rdy_at = ready;
        end
      end
      if (dn > 0 && c == dn + 1) begin
        sp_after = int'(spi_special);
        if (hold) start = 1'b0;
      end
      prev_clk = spi_clk; prev_cs = spi_cs; prev_sp = spi_special;
    end

    if (abort_fall >= 0) begin
      check("abort_falls", nfall, abort_fall + 1);
      check("abort_ndone", ndone, 0);
      check("abort_ready", int'(ready), 1);
    end else begin
      check("special_low_t", sp_lo, sel ? 1 : -1);
      check("cs_low_t", cs_lo, 1 + D);
      check("n_falls", nfall, 16);
      check("fall_timing_errs", fall_err, 0);
      check("mosi_word", int'(mosi_w), int'({a, v}));
      check("cs_high_t", cs_hi, 1 + 34 * D);
      check("special_high_t", sp_hi, sel ? 1 + 35 * D : -1);
      check("done_t", dn, 1 + 36 * D);
      check("n_done", ndone, 1);
      check("rx_data", int'(rx_at), int'(w));
      check("ready_at_done", int'(rdy_at), 1);
      if (hold) begin
        check("held_start_special", sp_after, 0);
        for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
        check("held_frame_ends", int'(ready), 1);
      end else begin
        check("post_ready", int'(ready), 1);
        check("post_cs", int'(spi_cs), 1);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; addr = '0; val = '0; special_sel = 1'b0; spi_miso = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of random activity.
    repeat (20) begin
      @(negedge clk);
      start = 1'($urandom); addr = 8'($urandom); val = 8'($urandom);
      special_sel = 1'($urandom); spi_miso = 1'($urandom);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); addr = 8'($urandom); val = 8'($urandom);
      special_sel = 1'($urandom); spi_miso = 1'($urandom);
    end
    check_idle("reset");
    rst = 1'b0; start = 1'b0;
    gap();

    run_frame(8'h07, 8'h03, 1'b1, 16'hA5C3, -1, -1, 1'b0);
    gap();
    run_frame(8'h12, 8'h34, 1'b0, 16'($urandom), -1, -1, 1'b0);
    gap();
    run_frame(8'($urandom), 8'($urandom), 1'($urandom), 16'($urandom), 30, -1, 1'b0);
    gap();
    run_frame(8'($urandom), 8'($urandom), 1'b1, 16'($urandom), -1, -1, 1'b1);
    gap();
    run_frame(8'($urandom), 8'($urandom), 1'b1, 16'($urandom), -1, 7, 1'b0);
    gap();
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 8'($urandom), 1'($urandom), 16'($urandom), -1, -1, 1'b0);
      gap();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
